// File: rtl/vp_pkg.sv
// -----------------------------------------------------------------------------
// vp_pkg
// Shared definitions for the video-pipeline frame controller slice:
//   - controller state encoding (IDLE / ARMED / ACTIVE)
//   - converter mode encoding driven onto cvt_mode
//   - default counter widths
// -----------------------------------------------------------------------------
package vp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } vp_state_e;

    // Converter mode encoding
    localparam logic [1:0] MODE_BT601  = 2'd0;
    localparam logic [1:0] MODE_BT709  = 2'd1;
    localparam logic [1:0] MODE_FULL   = 2'd2;
    localparam logic [1:0] MODE_BYPASS = 2'd3;

    localparam int unsigned CNT_W_DEF  = 12;
    localparam int unsigned FCNT_W_DEF = 16;

endpackage

// File: rtl/vp_timing_meas.sv
// -----------------------------------------------------------------------------
// vp_timing_meas
// Sync edge detection and raster measurement for vp_frame_ctrl.
//   clk, rst        pixel clock, async active-high reset
//   i_vs, i_de      vertical sync / data enable snooped from the pipeline
//   o_vs_rise       combinational vs rising edge (vs & ~vs_q)
//   o_vs_rise_q     o_vs_rise registered; the frame commit strobe
//   o_line_pix      pixel count of the most recently completed line
//   o_line_cnt      lines completed in the current frame
// Counters saturate at all-ones and clear on the commit strobe.
// -----------------------------------------------------------------------------
module vp_timing_meas #(
    parameter int unsigned CNT_W = vp_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vs,
    input  logic             i_de,
    output logic             o_vs_rise,
    output logic             o_vs_rise_q,
    output logic [CNT_W-1:0] o_line_pix,
    output logic [CNT_W-1:0] o_line_cnt
);

    logic             r_vs_q;
    logic             r_de_q;
    logic             r_rise_q;
    logic [CNT_W-1:0] r_pix;
    logic [CNT_W-1:0] r_line;
    logic [CNT_W-1:0] r_line_pix;

    logic w_vs_rise;
    logic w_de_fall;

    assign w_vs_rise = i_vs & ~r_vs_q;
    assign w_de_fall = ~i_de & r_de_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_q     <= 1'b0;
            r_de_q     <= 1'b0;
            r_rise_q   <= 1'b0;
            r_pix      <= '0;
            r_line     <= '0;
            r_line_pix <= '0;
        end else begin
            r_vs_q   <= i_vs;
            r_de_q   <= i_de;
            r_rise_q <= w_vs_rise;
            if (r_rise_q) begin
                r_pix  <= '0;
                r_line <= '0;
            end else if (w_de_fall) begin
                r_line_pix <= r_pix;
                r_pix      <= '0;
                if (r_line != '1) begin
                    r_line <= r_line + CNT_W'(1);
                end
            end else if (i_de && !i_vs && (r_pix != '1)) begin
                // de during vertical sync is blanking, not picture
                r_pix <= r_pix + CNT_W'(1);
            end
        end
    end

    assign o_vs_rise   = w_vs_rise;
    assign o_vs_rise_q = r_rise_q;
    assign o_line_pix  = r_line_pix;
    assign o_line_cnt  = r_line;

endmodule

// File: rtl/vp_frame_ctrl.sv
// -----------------------------------------------------------------------------
// vp_frame_ctrl
// Frame-synchronous configuration controller for the RGB->YCbCr converter.
// Software enable/mode settings are held in a shadow and committed only at a
// vertical-sync rising edge; also measures line/frame size and counts frames.
//   clk, rst            pixel clock, async active-high reset
//   cfg_wr/en/mode      shadow register write
//   start, stop         arm controller / return to idle at next frame boundary
//   vs, de              sync snooped from the converter input
//   cvt_en, cvt_mode    converter configuration
//   busy                controller in ARMED or ACTIVE
//   frame_done          one-cycle pulse per completed frame
//   h_last, v_last      size of the last completed frame
//   frame_cnt           completed frames since start (wraps)
//   size_err            sticky size mismatch, cleared by start
// Build option: VP_FRAME_CTRL_SIZE_CHECK_EN enables the size comparators;
// otherwise size_err is constant 0.
// -----------------------------------------------------------------------------
module vp_frame_ctrl
    import vp_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned FCNT_W = FCNT_W_DEF,
    parameter int unsigned H_EXP  = 1280,
    parameter int unsigned V_EXP  = 720
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic              cfg_en,
    input  logic [1:0]        cfg_mode,
    input  logic              start,
    input  logic              stop,
    input  logic              vs,
    input  logic              de,
    output logic              cvt_en,
    output logic [1:0]        cvt_mode,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  h_last,
    output logic [CNT_W-1:0]  v_last,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              size_err
);

    // Expected sizes must be representable in the measurement counters.
    if ((H_EXP >= (64'd1 << CNT_W)) || (V_EXP >= (64'd1 << CNT_W))) begin : g_bad_exp
        $error("vp_frame_ctrl: H_EXP/V_EXP exceed CNT_W");
    end

    vp_state_e r_state;
    vp_state_e w_state_nx;

    logic              r_sh_en;
    logic [1:0]        r_sh_mode;
    logic              r_snap_en;
    logic [1:0]        r_snap_mode;
    logic              r_stop_pend;
    logic              r_cvt_en;
    logic [1:0]        r_cvt_mode;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_h_last;
    logic [CNT_W-1:0]  r_v_last;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic              w_vs_rise;
    logic              w_commit;
    logic              w_start_ok;
    logic [CNT_W-1:0]  w_line_pix;
    logic [CNT_W-1:0]  w_line_cnt;

    vp_timing_meas #(.CNT_W(CNT_W)) u_meas (
        .clk         (clk),
        .rst         (rst),
        .i_vs        (vs),
        .i_de        (de),
        .o_vs_rise   (w_vs_rise),
        .o_vs_rise_q (w_commit),
        .o_line_pix  (w_line_pix),
        .o_line_cnt  (w_line_cnt)
    );

    // stop has priority over a simultaneous start
    assign w_start_ok = (r_state == ST_IDLE) && start && !stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nx = ST_ARMED;
                end
            end
            ST_ARMED, ST_ACTIVE: begin
                if (w_commit) begin
                    w_state_nx = r_stop_pend ? ST_IDLE : ST_ACTIVE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_en      <= 1'b0;
            r_sh_mode    <= MODE_BT601;
            r_snap_en    <= 1'b0;
            r_snap_mode  <= MODE_BT601;
            r_stop_pend  <= 1'b0;
            r_cvt_en     <= 1'b0;
            r_cvt_mode   <= MODE_BT601;
            r_frame_done <= 1'b0;
            r_h_last     <= '0;
            r_v_last     <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= 1'b0;

            if (cfg_wr) begin
                r_sh_en   <= cfg_en;
                r_sh_mode <= cfg_mode;
            end

            // Snapshot at the vs edge so a cfg_wr landing on that edge
            // is held off until the following frame.
            if (w_vs_rise) begin
                r_snap_en   <= r_sh_en;
                r_snap_mode <= r_sh_mode;
            end

            if ((r_state != ST_IDLE) && (w_state_nx == ST_IDLE)) begin
                r_stop_pend <= 1'b0;
            end else if (stop && (r_state != ST_IDLE)) begin
                r_stop_pend <= 1'b1;
            end

            if (w_start_ok) begin
                r_frame_cnt <= '0;
            end

            if (w_commit && (r_state != ST_IDLE)) begin
                if (r_stop_pend) begin
                    r_cvt_en <= 1'b0;
                end else begin
                    r_cvt_en   <= r_snap_en;
                    r_cvt_mode <= r_snap_mode;
                end
            end

            if (w_commit && (r_state == ST_ACTIVE)) begin
                r_h_last     <= w_line_pix;
                r_v_last     <= w_line_cnt;
                r_frame_done <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

`ifdef VP_FRAME_CTRL_SIZE_CHECK_EN
    logic r_size_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size_err <= 1'b0;
        end else if (w_start_ok) begin
            r_size_err <= 1'b0;
        end else if (w_commit && (r_state == ST_ACTIVE) &&
                     ((w_line_pix != CNT_W'(H_EXP)) || (w_line_cnt != CNT_W'(V_EXP)))) begin
            r_size_err <= 1'b1;
        end
    end

    assign size_err = r_size_err;
`else
    assign size_err = 1'b0;
`endif

    assign busy       = (r_state != ST_IDLE);
    assign cvt_en     = r_cvt_en;
    assign cvt_mode   = r_cvt_mode;
    assign frame_done = r_frame_done;
    assign h_last     = r_h_last;
    assign v_last     = r_v_last;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vp_frame_ctrl.sv
`timescale 1ns/1ps
module tb_vp_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr, cfg_en, start, stop, vs, de;
    logic [1:0]  cfg_mode;
    logic        cvt_en, busy, frame_done, size_err;
    logic [1:0]  cvt_mode;
    logic [11:0] h_last, v_last;
    logic [15:0] frame_cnt;

    int vectors   = 0;
    int miscmps   = 0;

`ifdef VP_FRAME_CTRL_SIZE_CHECK_EN
    localparam logic EXP_SE = 1'b1;
`else
    localparam logic EXP_SE = 1'b0;
`endif

    always #5 clk = ~clk;

    vp_frame_ctrl #(.CNT_W(12), .FCNT_W(16), .H_EXP(16), .V_EXP(4)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .start(start), .stop(stop), .vs(vs), .de(de),
        .cvt_en(cvt_en), .cvt_mode(cvt_mode), .busy(busy), .frame_done(frame_done),
        .h_last(h_last), .v_last(v_last), .frame_cnt(frame_cnt), .size_err(size_err)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input logic en, input logic [1:0] m);
        cfg_en = en; cfg_mode = m; cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(1); stop = 1'b0;
    endtask

    // vs rises; return at rise+2 where the commit is visible
    task automatic vs_up2();
        vs = 1'b1; tick(2);
    endtask

    task automatic vs_down();
        tick(1); vs = 1'b0; tick(2);
    endtask

    task automatic send_line(input int n);
        de = 1'b1; tick(n);
        de = 1'b0; tick(2);
    endtask

    task automatic send_frame(input int lines, input int pix);
        for (int i = 0; i < lines; i++) send_line(pix);
    endtask

    task automatic test_reset();
        vectors++;
        if ({cvt_en, cvt_mode, busy, frame_done, h_last, v_last, frame_cnt, size_err} !== '0) begin
            miscmps++;
            $display("FAIL reset_outputs: got en=%0b mode=%0d busy=%0b fd=%0b h=%0d v=%0d cnt=%0d se=%0b want all 0",
                     cvt_en, cvt_mode, busy, frame_done, h_last, v_last, frame_cnt, size_err);
        end
    endtask

    task automatic test_commit();
        cfg(1'b1, 2'd2);
        pulse_start();
        vectors++;
        if ({busy, cvt_en, frame_done} !== 3'b100) begin
            miscmps++;
            $display("FAIL armed: got busy=%0b en=%0b fd=%0b want 1,0,0", busy, cvt_en, frame_done);
        end
        vs = 1'b1; tick(1);
        vectors++;
        if (cvt_en !== 1'b0) begin
            miscmps++;
            $display("FAIL commit_rise1: got en=%0b want 0", cvt_en);
        end
        tick(1);
        vectors++;
        if ({cvt_en, cvt_mode, busy, frame_done} !== 5'b1_10_1_0) begin
            miscmps++;
            $display("FAIL commit_rise2: got en=%0b mode=%0d busy=%0b fd=%0b want 1,2,1,0",
                     cvt_en, cvt_mode, busy, frame_done);
        end
        vs_down();
    endtask

    task automatic test_frames();
        send_frame(4, 16);
        vs_up2();
        vectors++;
        if (frame_done !== 1'b1) begin
            miscmps++;
            $display("FAIL frame1_done: got %0b want 1", frame_done);
        end
        vectors++;
        if ({h_last, v_last, frame_cnt} !== {12'd16, 12'd4, 16'd1}) begin
            miscmps++;
            $display("FAIL frame1_size: got h=%0d v=%0d cnt=%0d want 16,4,1", h_last, v_last, frame_cnt);
        end
        tick(1);
        vectors++;
        if (frame_done !== 1'b0) begin
            miscmps++;
            $display("FAIL frame_done_width: got %0b want 0", frame_done);
        end
        tick(1); vs = 1'b0; tick(2);
    endtask

    task automatic test_cfg_midframe();
        send_line(5);
        cfg(1'b0, 2'd1);
        send_line(5);
        send_line(5);
        vs = 1'b1; tick(1);
        vectors++;
        if ({cvt_en, cvt_mode} !== 3'b1_10) begin
            miscmps++;
            $display("FAIL midcfg_hold: got en=%0b mode=%0d want 1,2", cvt_en, cvt_mode);
        end
        tick(1);
        vectors++;
        if ({cvt_en, cvt_mode} !== 3'b0_01) begin
            miscmps++;
            $display("FAIL midcfg_apply: got en=%0b mode=%0d want 0,1", cvt_en, cvt_mode);
        end
        vectors++;
        if ({h_last, v_last, frame_cnt} !== {12'd5, 12'd3, 16'd2}) begin
            miscmps++;
            $display("FAIL frame2_size: got h=%0d v=%0d cnt=%0d want 5,3,2", h_last, v_last, frame_cnt);
        end
        vs_down();
    endtask

    task automatic test_cfg_at_vsrise();
        send_frame(2, 7);
        cfg_en = 1'b1; cfg_mode = 2'd3; cfg_wr = 1'b1; vs = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        tick(1);
        vectors++;
        if ({cvt_en, cvt_mode} !== 3'b0_01) begin
            miscmps++;
            $display("FAIL cfg_at_rise_old: got en=%0b mode=%0d want 0,1", cvt_en, cvt_mode);
        end
        vectors++;
        if ({h_last, v_last, frame_cnt} !== {12'd7, 12'd2, 16'd3}) begin
            miscmps++;
            $display("FAIL frame3_size: got h=%0d v=%0d cnt=%0d want 7,2,3", h_last, v_last, frame_cnt);
        end
        vs_down();
        send_frame(4, 16);
        vs_up2();
        vectors++;
        if ({cvt_en, cvt_mode, frame_cnt} !== {1'b1, 2'd3, 16'd4}) begin
            miscmps++;
            $display("FAIL cfg_at_rise_new: got en=%0b mode=%0d cnt=%0d want 1,3,4", cvt_en, cvt_mode, frame_cnt);
        end
        vs_down();
    endtask

    task automatic test_stop();
        send_line(16);
        pulse_stop();
        vectors++;
        if (busy !== 1'b1) begin
            miscmps++;
            $display("FAIL stop_pending_busy: got %0b want 1", busy);
        end
        send_frame(3, 16);
        vs_up2();
        vectors++;
        if ({busy, cvt_en, frame_done, frame_cnt} !== {3'b001, 16'd5}) begin
            miscmps++;
            $display("FAIL stop_to_idle: got busy=%0b en=%0b fd=%0b cnt=%0d want 0,0,1,5",
                     busy, cvt_en, frame_done, frame_cnt);
        end
        vs_down();
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1; tick(1);
        start = 1'b0; stop = 1'b0;
        vectors++;
        if ({busy, frame_cnt} !== {1'b0, 16'd5}) begin
            miscmps++;
            $display("FAIL start_stop_idle: got busy=%0b cnt=%0d want 0,5", busy, frame_cnt);
        end
        vs_up2();
        vectors++;
        if ({frame_done, cvt_en, busy} !== 3'b000) begin
            miscmps++;
            $display("FAIL idle_vs: got fd=%0b en=%0b busy=%0b want 0,0,0", frame_done, cvt_en, busy);
        end
        vs_down();
    endtask

    task automatic test_size_check();
        pulse_stop();
        pulse_start();
        vectors++;
        if ({busy, frame_cnt, size_err} !== {1'b1, 16'd0, 1'b0}) begin
            miscmps++;
            $display("FAIL restart: got busy=%0b cnt=%0d se=%0b want 1,0,0", busy, frame_cnt, size_err);
        end
        vs_up2();
        vectors++;
        if ({cvt_en, cvt_mode, frame_done} !== 4'b1_11_0) begin
            miscmps++;
            $display("FAIL restart_commit: got en=%0b mode=%0d fd=%0b want 1,3,0", cvt_en, cvt_mode, frame_done);
        end
        vs_down();
        send_frame(4, 15);
        vs_up2();
        vectors++;
        if ({h_last, v_last, frame_cnt, busy} !== {12'd15, 12'd4, 16'd1, 1'b1}) begin
            miscmps++;
            $display("FAIL short_frame: got h=%0d v=%0d cnt=%0d busy=%0b want 15,4,1,1",
                     h_last, v_last, frame_cnt, busy);
        end
        vectors++;
        if (size_err !== EXP_SE) begin
            miscmps++;
            $display("FAIL size_err_set: got %0b want %0b", size_err, EXP_SE);
        end
        vs_down();
        send_frame(4, 16);
        vs_up2();
        vectors++;
        if ({size_err, frame_cnt} !== {EXP_SE, 16'd2}) begin
            miscmps++;
            $display("FAIL size_err_sticky: got se=%0b cnt=%0d want %0b,2", size_err, frame_cnt, EXP_SE);
        end
        vs_down();
        pulse_stop();
        send_frame(1, 4);
        vs_up2();
        vs_down();
        pulse_start();
        vectors++;
        if ({size_err, frame_cnt, busy} !== {1'b0, 16'd0, 1'b1}) begin
            miscmps++;
            $display("FAIL size_err_clear: got se=%0b cnt=%0d busy=%0b want 0,0,1", size_err, frame_cnt, busy);
        end
    endtask

    task automatic test_reset_midline();
        vs_up2();
        vs_down();
        de = 1'b1; tick(3);
        vectors++;
        if ({cvt_en, h_last} !== {1'b1, 12'd4}) begin
            miscmps++;
            $display("FAIL pre_reset: got en=%0b h=%0d want 1,4", cvt_en, h_last);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({cvt_en, cvt_mode, busy, frame_done, h_last, v_last, frame_cnt, size_err} !== '0) begin
            miscmps++;
            $display("FAIL reset_midline: got en=%0b mode=%0d busy=%0b h=%0d v=%0d cnt=%0d want all 0",
                     cvt_en, cvt_mode, busy, h_last, v_last, frame_cnt);
        end
        tick(1);
        de = 1'b0; rst = 1'b0;
        tick(1);
        cfg(1'b1, 2'd2);
        pulse_start();
        vs_up2();
        vectors++;
        if ({cvt_en, cvt_mode, frame_done} !== 4'b1_10_0) begin
            miscmps++;
            $display("FAIL post_reset_commit: got en=%0b mode=%0d fd=%0b want 1,2,0", cvt_en, cvt_mode, frame_done);
        end
        vs_down();
        send_frame(2, 9);
        vs_up2();
        vectors++;
        if ({h_last, v_last, frame_cnt, frame_done} !== {12'd9, 12'd2, 16'd1, 1'b1}) begin
            miscmps++;
            $display("FAIL post_reset_frame: got h=%0d v=%0d cnt=%0d fd=%0b want 9,2,1,1",
                     h_last, v_last, frame_cnt, frame_done);
        end
        vs_down();
    endtask

    initial begin
        rst = 1'b1;
        cfg_wr = 1'b0; cfg_en = 1'b0; cfg_mode = 2'd0;
        start = 1'b0; stop = 1'b0; vs = 1'b0; de = 1'b0;
        tick(2);
        test_reset();
        rst = 1'b0;
        tick(1);
        test_commit();
        test_frames();
        test_cfg_midframe();
        test_cfg_at_vsrise();
        test_stop();
        test_start_stop();
        test_size_check();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmps);
        $finish;
    end

endmodule
